// File: rtl/prbs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prbs_pkg
// Brief    : PRBS9 constants and BER checker state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package prbs_pkg;

  localparam int         c_prbs9_w      = 9;
  localparam int         c_prbs9_tap_hi = 8;
  localparam int         c_prbs9_tap_lo = 4;
  localparam logic [8:0] c_prbs9_seed   = 9'h1AA;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } ber_state_t;

  function automatic logic prbs9_pred(input logic [c_prbs9_w-1:0] p);
    return p[c_prbs9_tap_hi] ^ p[c_prbs9_tap_lo];
  endfunction

endpackage
`default_nettype wire

// File: rtl/prbs9_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : prbs9_lfsr
// Brief    : PRBS9 (x^9+x^5+1) register, shifts in external data or feedback.
// Revision : 1.0 - initial release
// ============================================================================
module prbs9_lfsr
  import prbs_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [c_prbs9_w-1:0] i_seed,
  input  logic                 i_shift,
  input  logic                 i_use_fb,
  input  logic                 i_din,
  output logic                 o_pred,
  output logic                 o_zero
);

  logic [c_prbs9_w-1:0] r_p;
  logic                 w_d;

  assign o_pred = prbs9_pred(r_p);
  assign o_zero = (r_p == '0);
  assign w_d    = i_use_fb ? o_pred : i_din;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p <= '0;
    end else if (i_load) begin
      r_p <= i_seed;
    end else if (i_shift) begin
      r_p <= {r_p[c_prbs9_w-2:0], w_d};
    end
  end

endmodule
`default_nettype wire

// File: rtl/ber_checker.sv
`default_nettype none
// ============================================================================
// Module   : ber_checker
// Brief    : Self-synchronising PRBS9 bit-error-rate checker with lock/loss FSM.
// Revision : 1.0 - initial release
// ============================================================================
module ber_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_LEN = 32,
  parameter int WIN_LEN  = 128,
  parameter int LOSS_THR = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             locked,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_pulse
);

  localparam int                c_mc_w      = $clog2(LOCK_LEN + 1);
  localparam int                c_wc_w      = $clog2(WIN_LEN + 1);
  localparam logic [c_mc_w-1:0] c_lock_last = c_mc_w'(LOCK_LEN - 1);
  localparam logic [c_wc_w-1:0] c_win_last  = c_wc_w'(WIN_LEN - 1);
  localparam logic [c_wc_w-1:0] c_loss_thr  = c_wc_w'(LOSS_THR);
  localparam logic [3:0]        c_load_last = 4'(c_prbs9_w - 1);

  ber_state_t        r_state;
  logic [3:0]        r_load_cnt;
  logic [c_mc_w-1:0] r_match_cnt;
  logic [c_wc_w-1:0] r_win_cnt;
  logic [c_wc_w-1:0] r_win_err;
  logic [CNT_W-1:0]  r_bit_count;
  logic [CNT_W-1:0]  r_err_count;
  logic              r_err_pulse;
  logic              r_locked;

  logic              w_pred;
  logic              w_zero;
  logic              w_mis;
  logic [c_wc_w-1:0] w_win_err_nx;

  // Once locked the predictor free-runs so received errors never corrupt it.
  prbs9_lfsr u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .i_load   (1'b0),
    .i_seed   (c_prbs9_seed),
    .i_shift  (bit_valid),
    .i_use_fb (r_state == ST_LOCKED),
    .i_din    (bit_in),
    .o_pred   (w_pred),
    .o_zero   (w_zero)
  );

  assign w_mis        = bit_in ^ w_pred;
  assign w_win_err_nx = r_win_err + c_wc_w'(w_mis);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_LOAD;
      r_load_cnt  <= '0;
      r_match_cnt <= '0;
      r_win_cnt   <= '0;
      r_win_err   <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_err_pulse <= 1'b0;
      if (bit_valid) begin
        case (r_state)
          ST_LOAD: begin
            if (r_load_cnt == c_load_last) begin
              r_state     <= ST_VERIFY;
              r_load_cnt  <= '0;
              r_match_cnt <= '0;
            end else begin
              r_load_cnt <= r_load_cnt + 4'd1;
            end
          end
          ST_VERIFY: begin
            // An all-zero predictor would happily "lock" to a dead line.
            if (w_zero) begin
              r_state    <= ST_LOAD;
              r_load_cnt <= '0;
            end else if (w_mis) begin
              r_match_cnt <= '0;
            end else if (r_match_cnt == c_lock_last) begin
              r_state   <= ST_LOCKED;
              r_locked  <= 1'b1;
              r_win_cnt <= '0;
              r_win_err <= '0;
            end else begin
              r_match_cnt <= r_match_cnt + c_mc_w'(1);
            end
          end
          ST_LOCKED: begin
            r_err_pulse <= w_mis;
            if (r_win_cnt == c_win_last) begin
              r_win_cnt <= '0;
              r_win_err <= '0;
              if (w_win_err_nx >= c_loss_thr) begin
                r_state    <= ST_LOAD;
                r_locked   <= 1'b0;
                r_load_cnt <= '0;
              end
            end else begin
              r_win_cnt <= r_win_cnt + c_wc_w'(1);
              r_win_err <= w_win_err_nx;
            end
          end
          default: begin
            r_state  <= ST_LOAD;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Saturating statistics; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_count <= '0;
      r_err_count <= '0;
    end else if (clr) begin
      r_bit_count <= '0;
      r_err_count <= '0;
    end else if (bit_valid && (r_state == ST_LOCKED)) begin
      if (r_bit_count != '1) begin
        r_bit_count <= r_bit_count + CNT_W'(1);
      end
      if (w_mis && (r_err_count != '1)) begin
        r_err_count <= r_err_count + CNT_W'(1);
      end
    end
  end

  assign locked    = r_locked;
  assign bit_count = r_bit_count;
  assign err_count = r_err_count;
  assign err_pulse = r_err_pulse;

endmodule
`default_nettype wire

// File: tb/tb_ber_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ber_checker
// Brief    : Randomised scoreboard bench for ber_checker (32-bit and 4-bit counters).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ber_checker;

  localparam int LOCK_LEN = 32;
  localparam int WIN_LEN  = 128;
  localparam int LOSS_THR = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_in = 1'b0;
  logic        locked, err_pulse, locked_s, err_pulse_s;
  logic [31:0] bit_count, err_count;
  logic [3:0]  bit_count_s, err_count_s;

  always #5 clk = ~clk;

  ber_checker #(.LOCK_LEN(LOCK_LEN), .WIN_LEN(WIN_LEN), .LOSS_THR(LOSS_THR), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .clr(clr), .bit_valid(bit_valid), .bit_in(bit_in),
    .locked(locked), .bit_count(bit_count), .err_count(err_count), .err_pulse(err_pulse)
  );

  ber_checker #(.LOCK_LEN(LOCK_LEN), .WIN_LEN(WIN_LEN), .LOSS_THR(LOSS_THR), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .clr(clr), .bit_valid(bit_valid), .bit_in(bit_in),
    .locked(locked_s), .bit_count(bit_count_s), .err_count(err_count_s), .err_pulse(err_pulse_s)
  );

  typedef struct {
    logic   lk;
    logic   pl;
    longint bc, ec, bcs, ecs;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;

  // Reference model: mode 0 acquire, 1 verify, 2 locked.
  int     m_mode, m_p, m_lc, m_mc, m_wc, m_we;
  longint m_bc, m_ec, m_bcs, m_ecs;
  int     g;

  function automatic void model_reset();
    m_mode = 0; m_p = 0; m_lc = 0; m_mc = 0; m_wc = 0; m_we = 0;
    m_bc = 0; m_ec = 0; m_bcs = 0; m_ecs = 0;
  endfunction

  function automatic logic gen_bit();
    int nb;
    nb = ((g >> 8) ^ (g >> 4)) & 1;
    g  = ((g << 1) | nb) & 511;
    return nb[0];
  endfunction

  function automatic exp_t model_step(input logic b, input logic c);
    exp_t e;
    int   pr;
    bit   mis;
    int   bi;
    bi  = b ? 1 : 0;
    pr  = ((m_p >> 8) ^ (m_p >> 4)) & 1;
    mis = (bi != pr);
    e.pl = 1'b0;
    case (m_mode)
      0: begin
        m_p = ((m_p << 1) | bi) & 511;
        m_lc++;
        if (m_lc == 9) begin m_mode = 1; m_mc = 0; end
      end
      1: begin
        if (m_p == 0) begin m_mode = 0; m_lc = 0; end
        else if (mis) m_mc = 0;
        else begin
          m_mc++;
          if (m_mc == LOCK_LEN) begin m_mode = 2; m_wc = 0; m_we = 0; end
        end
        m_p = ((m_p << 1) | bi) & 511;
      end
      default: begin
        m_p = ((m_p << 1) | pr) & 511;
        if (m_bc < 64'hFFFF_FFFF) m_bc++;
        if (m_bcs < 15) m_bcs++;
        if (mis) begin
          if (m_ec < 64'hFFFF_FFFF) m_ec++;
          if (m_ecs < 15) m_ecs++;
        end
        e.pl = mis;
        m_wc++;
        m_we += mis ? 1 : 0;
        if (m_wc == WIN_LEN) begin
          if (m_we >= LOSS_THR) begin m_mode = 0; m_lc = 0; end
          m_wc = 0; m_we = 0;
        end
      end
    endcase
    if (c) begin m_bc = 0; m_ec = 0; m_bcs = 0; m_ecs = 0; end
    e.lk = (m_mode == 2); e.bc = m_bc; e.ec = m_ec; e.bcs = m_bcs; e.ecs = m_ecs;
    return e;
  endfunction

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: one expected record per sampled strobe, compared a half cycle later.
  logic seen = 1'b0;
  always @(posedge clk) seen <= bit_valid;

  always @(negedge clk) begin : mon
    exp_t e;
    if (seen) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("locked",      locked,      e.lk);
        chk("err_pulse",   err_pulse,   e.pl);
        chk("bit_count",   bit_count,   e.bc);
        chk("err_count",   err_count,   e.ec);
        chk("locked_s",    locked_s,    e.lk);
        chk("err_pulse_s", err_pulse_s, e.pl);
        chk("bit_count_s", bit_count_s, e.bcs);
        chk("err_count_s", err_count_s, e.ecs);
      end
    end else begin
      chk("idle_pulse",   err_pulse,   0);
      chk("idle_pulse_s", err_pulse_s, 0);
    end
  end

  task automatic send(input logic b, input logic c, input int gap);
    bit_valid = 1'b1; bit_in = b; clr = c;
    sb.push_back(model_step(b, c));
    @(posedge clk); #1;
    bit_valid = 1'b0; bit_in = 1'b0; clr = 1'b0;
    repeat (gap - 1) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("rst_locked",    locked,      0);
    chk("rst_bit_count", bit_count,   0);
    chk("rst_err_count", err_count,   0);
    chk("rst_err_pulse", err_pulse,   0);
    chk("rst_locked_s",  locked_s,    0);
    chk("rst_bit_cnt_s", bit_count_s, 0);
    chk("rst_err_cnt_s", err_count_s, 0);
    model_reset();
    g = 9'h1AA;
    @(negedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic acquire(input int gap);
    for (int i = 1; i <= 41; i++) begin
      send(gen_bit(), 1'b0, gap);
      if (i == 40) chk("lock_at_40", locked, 0);
      if (i == 41) chk("lock_at_41", locked, 1);
    end
  endtask

  initial begin : stim
    bit ever;
    model_reset();
    g = 9'h1AA;
    do_reset();

    acquire(4);
    repeat (1000) send(gen_bit(), 1'b0, 4);
    chk("clean_bit_count", bit_count, 1000);
    chk("clean_err_count", err_count, 0);
    chk("clean_bit_sat",   bit_count_s, 15);

    send(~gen_bit(), 1'b0, 1);
    chk("single_pulse", err_pulse, 1);
    repeat (3) begin @(posedge clk); #1; end
    repeat (200) send(gen_bit(), 1'b0, 4);
    chk("single_err_count", err_count, 1);
    chk("single_locked",    locked, 1);

    while (m_wc != 0) send(gen_bit(), 1'b0, 4);
    repeat (20) send(~gen_bit(), 1'b0, 4);
    chk("pre_close_locked", locked, 1);
    do send(gen_bit(), 1'b0, 4); while (m_wc != 0);
    chk("loss_unlocked", locked, 0);
    acquire(4);
    chk("loss_err_kept", err_count, 21);
    chk("err_sat_s",     err_count_s, 15);

    send(~gen_bit(), 1'b1, 1);
    chk("clr_bit_count",   bit_count, 0);
    chk("clr_err_count",   err_count, 0);
    chk("clr_err_count_s", err_count_s, 0);
    chk("clr_locked",      locked, 1);
    repeat (50) send(gen_bit(), 1'b0, 4);

    do_reset();
    acquire(1);
    repeat (100) send(gen_bit(), 1'b0, 1);
    chk("b2b_bit_count", bit_count, 100);
    chk("b2b_err_count", err_count, 0);

    do_reset();
    ever = 1'b0;
    repeat (10000) begin
      send(1'($urandom_range(0, 1)), 1'b0, 1);
      if (locked) ever = 1'b1;
    end
    chk("random_no_lock", ever, 0);

    ever = 1'b0;
    repeat (300) begin
      send(1'b0, 1'b0, 4);
      if (locked) ever = 1'b1;
    end
    chk("zero_no_lock", ever, 0);

    @(negedge clk); #1;
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
